data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Data-memory responder on the core's load/store port: serves MemRead/MemWrite from the
//   pipelined RV32I core's MEM stage. Word-organised RAM with byte/half/word access selected
//   by funct3 and a registered read path. Zero-fills all words after reset before accepting
//   requests.
// PARAMETERS
//   SIZE            32   data word width (bits); byte lanes = SIZE/8, fixed 4
//   ADDR_WIDTH      10   word-address width; DEPTH = 2**ADDR_WIDTH words
//   CLEAR_ON_RESET  1    1: run CLEAR sweep after reset; 0: go straight to IDLE
// PORTS
//   CLK        in   1           clock, all state on rising edge
//   RESET      in   1           synchronous, active-high reset
//   daddr      in   ADDR_WIDTH  word address of access
//   byte_off   in   2           byte offset within word (ALU result [1:0])
//   funct3     in   3           RV32I load/store width/sign code
//   MemRead    in   1           load request, sampled when READY=1
//   MemWrite   in   1           store request, sampled when READY=1
//   ddata_w    in   SIZE        store data, low-aligned (rs2)
//   ddata_r    out  SIZE        load data, extended per funct3
//   rvalid     out  1           ddata_r valid this cycle (1-cycle pulse)
//   READY      out  1           1 = requests accepted (IDLE)
//   ERR        out  1           sticky: illegal/misaligned/conflicting access seen
// BEHAVIOUR
//   - Reset: ddata_r=0, rvalid=0, ERR=0, clear_ptr=0; state=CLEAR (IDLE if CLEAR_ON_RESET=0).
//   - FSM CLEAR: READY=0; write 0 to word clear_ptr each cycle, clear_ptr++; after word
//     DEPTH-1 -> IDLE (exactly DEPTH cycles). Requests during CLEAR ignored, no rvalid, no ERR.
//   - RESET mid-CLEAR restarts sweep at 0; RESET in IDLE clears outputs (RAM contents kept
//     only if CLEAR_ON_RESET=0).
//   - IDLE: READY=1. Stores: SB(000) writes lane byte_off; SH(001) lanes {byte_off+1,byte_off};
//     SW(010) all lanes; unwritten lanes unchanged. Data taken from ddata_w low bits, shifted.
//   - Loads: 1-cycle latency. Request at edge N -> ddata_r/rvalid valid after edge N+1,
//     rvalid low otherwise. LB(000)/LH(001) sign-extend; LBU(100)/LHU(101) zero-extend; LW(010).
//   - Write then read of same word on the next cycle returns the new data.
//   - Illegal: misaligned (half with byte_off[0]=1; word with byte_off!=0) or undefined funct3
//     (load 011/110/111, store >=011) -> RAM unchanged, ERR<=1; for loads rvalid still pulses
//     with ddata_r=0 so the core never stalls.
//   - MemRead & MemWrite together: perform the write only, no rvalid, ERR<=1.
//   - ERR clears only on RESET.
// STRUCTURE
//   - Package mem_access_pkg: funct3 constants F3_B/H/W/BU/HU, state enum {CLEAR, IDLE}.
//   - Sub-module load_align (combinational): raw word + byte_off + funct3 -> extended data.
//   - Storage: DEPTH x 4 byte-lane array, per-lane write enables, registered read.
// TESTING
//   - Reset, CLEAR_ON_RESET=1 -> READY=0 for exactly 1024 cycles; then LW any addr -> 0.
//   - SW daddr=5 data=0xDEADBEEF; next cycle LW daddr=5 -> ddata_r=0xDEADBEEF, rvalid one cycle later.
//   - SB daddr=5 off=2 data=0x7F; LW -> 0xDE7FBEEF; LB off=3 -> 0xFFFFFFDE; LBU off=3 -> 0x000000DE.
//   - LH off=1 -> ERR=1, rvalid=1, ddata_r=0; SW off=2 -> word unchanged, ERR stays 1.
//   - Assert RESET at CLEAR cycle 300 -> sweep restarts, READY rises 1024 cycles after release.
//   - MemRead=MemWrite=1 SW 0x12345678 daddr=9 -> no rvalid, ERR=1; later LW daddr=9 -> 0x12345678.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared constants, state encoding and access-legality helper for the data-memory responder.
package mem_access_pkg;

    // RV32I load/store width codes (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Responder FSM states
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    // Legacy-compatible encodings used by the state register
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    // True when funct3/byte_off describe a defined, naturally aligned access.
    // Unsigned widths (BU/HU) exist only for loads.
    function automatic logic access_legal(input logic       is_load,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = is_load;
            F3_HU:   ok = is_load & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store port between the core's MEM stage (master) and the data-memory responder (slave).
interface data_mem_responder_if #(
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = 10
) ();

    logic [ADDR_WIDTH-1:0] daddr;
    logic [1:0]            byte_off;
    logic [2:0]            funct3;
    logic                  MemRead;
    logic                  MemWrite;
    logic [SIZE-1:0]       ddata_w;
    logic [SIZE-1:0]       ddata_r;
    logic                  rvalid;
    logic                  READY;
    logic                  ERR;

    modport master (
        output daddr, byte_off, funct3, MemRead, MemWrite, ddata_w,
        input  ddata_r, rvalid, READY, ERR
    );

    modport slave (
        input  daddr, byte_off, funct3, MemRead, MemWrite, ddata_w,
        output ddata_r, rvalid, READY, ERR
    );

endinterface

// File: rtl/load_align.sv
// Combinational load formatter: selects the addressed byte/half of a raw word and
// sign- or zero-extends it according to funct3. Undefined codes yield zero.
module load_align
    import mem_access_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] raw_word,
    input  logic [1:0]      byte_off,
    input  logic [2:0]      funct3,
    output logic [SIZE-1:0] load_data
);

    logic [SIZE-1:0] shifted_s;

    // Move the addressed lane down to bit 0, then extend per access width
    always_comb begin
        shifted_s = raw_word >> {byte_off, 3'b000};
        case (funct3)
            F3_B:    load_data = {{(SIZE-8){shifted_s[7]}},   shifted_s[7:0]};
            F3_H:    load_data = {{(SIZE-16){shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    load_data = raw_word;
            F3_BU:   load_data = {{(SIZE-8){1'b0}},           shifted_s[7:0]};
            F3_HU:   load_data = {{(SIZE-16){1'b0}},          shifted_s[15:0]};
            default: load_data = {SIZE{1'b0}};
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the RV32I MEM stage: word-organised byte-lane RAM with
// byte/half/word stores, registered reads formatted by load_align, a post-reset
// zero-fill sweep, and a sticky error flag for illegal or conflicting accesses.
module data_mem_responder
    import mem_access_pkg::*;
#(
    parameter int SIZE           = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    data_mem_responder_if.slave  bus
);

    localparam int                    DEPTH       = 2 ** ADDR_WIDTH;
    localparam int                    LANES       = SIZE / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [0:0]            RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    // Storage and read pipeline
    logic [SIZE-1:0]       mem_r [DEPTH];
    logic [SIZE-1:0]       rd_word_r;
    logic [1:0]            rd_off_r;
    logic [2:0]            rd_f3_r;
    logic                  rd_pend_r;
    logic                  rd_bad_r;

    // Control and outputs
    logic [0:0]            state_r;
    logic [ADDR_WIDTH-1:0] clear_ptr_r;
    logic                  err_r;
    logic [SIZE-1:0]       rdata_r;
    logic                  rvalid_r;

    // Request decode and write port
    logic                  ready_s;
    logic                  rd_req_s;
    logic                  wr_req_s;
    logic                  conflict_s;
    logic                  st_legal_s;
    logic                  ld_legal_s;
    logic                  err_set_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [LANES-1:0]      mem_be_s;
    logic [SIZE-1:0]       mem_wdata_s;
    logic [SIZE-1:0]       aligned_s;

    // Decode the request and select between the clear sweep and core stores
    always_comb begin
        ready_s     = (state_r == ST_IDLE);
        wr_req_s    = ready_s & bus.MemWrite;
        rd_req_s    = ready_s & bus.MemRead & ~bus.MemWrite;
        conflict_s  = ready_s & bus.MemRead & bus.MemWrite;
        st_legal_s  = access_legal(1'b0, bus.funct3, bus.byte_off);
        ld_legal_s  = access_legal(1'b1, bus.funct3, bus.byte_off);
        err_set_s   = conflict_s | (wr_req_s & ~st_legal_s) | (rd_req_s & ~ld_legal_s);
        mem_we_s    = 1'b0;
        mem_addr_s  = bus.daddr;
        mem_be_s    = {LANES{1'b0}};
        mem_wdata_s = {SIZE{1'b0}};
        if (RESET) begin
            // RAM must be left untouched while reset is held
            mem_we_s = 1'b0;
        end else if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clear_ptr_r;
            mem_be_s    = {LANES{1'b1}};
            mem_wdata_s = {SIZE{1'b0}};
        end else if (wr_req_s && st_legal_s) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = bus.daddr;
            mem_wdata_s = bus.ddata_w << {bus.byte_off, 3'b000};
            case (bus.funct3)
                F3_B:    mem_be_s = {{(LANES-1){1'b0}}, 1'b1}  << bus.byte_off;
                F3_H:    mem_be_s = {{(LANES-2){1'b0}}, 2'b11} << bus.byte_off;
                F3_W:    mem_be_s = {LANES{1'b1}};
                default: mem_be_s = {LANES{1'b0}};
            endcase
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Byte-lane RAM write and registered raw-word read (no reset, RAM-inferable)
    always_ff @(posedge CLK) begin
        for (int i = 0; i < LANES; i++) begin
            if (mem_we_s && mem_be_s[i]) begin
                mem_r[mem_addr_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
            end
        end
        rd_word_r <= mem_r[bus.daddr];
        rd_off_r  <= bus.byte_off;
        rd_f3_r   <= bus.funct3;
    end

    load_align #(.SIZE(SIZE)) u_load_align (
        .raw_word  (rd_word_r),
        .byte_off  (rd_off_r),
        .funct3    (rd_f3_r),
        .load_data (aligned_s)
    );

    // FSM: zero-fill sweep over every word, then serve requests
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= RESET_STATE;
            clear_ptr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clear_ptr_r <= clear_ptr_r + ADDR_WIDTH'(1);
                    if (clear_ptr_r == LAST_ADDR) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IDLE:  state_r <= ST_IDLE;
                default:  state_r <= RESET_STATE;
            endcase
        end
    end

    // Load response pipeline and sticky error flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_pend_r <= 1'b0;
            rd_bad_r  <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= {SIZE{1'b0}};
            err_r     <= 1'b0;
        end else begin
            rd_pend_r <= rd_req_s;
            rd_bad_r  <= rd_req_s & ~ld_legal_s;
            rvalid_r  <= rd_pend_r;
            if (rd_pend_r) begin
                // Illegal loads still answer (with zero) so the core never stalls
                rdata_r <= rd_bad_r ? {SIZE{1'b0}} : aligned_s;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign bus.ddata_r = rdata_r;
    assign bus.rvalid  = rvalid_r;
    assign bus.READY   = ready_s;
    assign bus.ERR     = err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (SIZE=32, ADDR_WIDTH=10, clear on reset).
module tb_data_mem_responder;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    logic CLK = 1'b0;
    logic RESET;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cycles;
    logic saw_rvalid;
    logic saw_err;

    always #5 CLK = ~CLK;

    data_mem_responder_if #(.SIZE(32), .ADDR_WIDTH(10)) bus ();

    data_mem_responder #(
        .SIZE(32), .ADDR_WIDTH(10), .CLEAR_ON_RESET(1)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_idle();
        bus.daddr    = 10'd0;
        bus.byte_off = 2'd0;
        bus.funct3   = 3'd0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.ddata_w  = 32'h0;
    endtask

    // Present one request for exactly one rising edge
    task automatic drive(input logic rd, input logic wr, input logic [9:0] addr,
                         input logic [1:0] off, input logic [2:0] f3, input logic [31:0] data);
        bus.daddr    = addr;
        bus.byte_off = off;
        bus.funct3   = f3;
        bus.MemRead  = rd;
        bus.MemWrite = wr;
        bus.ddata_w  = data;
        tick();
        bus_idle();
    endtask

    task automatic store(input logic [9:0] addr, input logic [1:0] off,
                         input logic [2:0] f3, input logic [31:0] data);
        drive(1'b0, 1'b1, addr, off, f3, data);
    endtask

    // Load: rvalid low right after the request edge, high with data after the next edge
    task automatic load(input string tag, input logic [9:0] addr, input logic [1:0] off,
                        input logic [2:0] f3, input logic [31:0] exp);
        drive(1'b1, 1'b0, addr, off, f3, 32'h0);
        chk({tag, "_early"}, {31'd0, bus.rvalid}, 32'd0);
        tick();
        chk({tag, "_rvalid"}, {31'd0, bus.rvalid}, 32'd1);
        chk(tag, bus.ddata_r, exp);
    endtask

    // Count cycles until READY rises (bounded), watching for stray rvalid/ERR
    task automatic wait_ready(output int n, output logic rv, output logic er);
        n  = 0;
        rv = 1'b0;
        er = 1'b0;
        while (bus.READY !== 1'b1 && n < 2000) begin
            tick();
            n++;
            if (bus.rvalid === 1'b1) rv = 1'b1;
            if (bus.ERR === 1'b1) er = 1'b1;
        end
    endtask

    initial begin
        bus_idle();
        RESET = 1'b1;
        tick(); tick(); tick();
        chk("rst_ready",  {31'd0, bus.READY},  32'd0);
        chk("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
        chk("rst_err",    {31'd0, bus.ERR},    32'd0);
        chk("rst_data",   bus.ddata_r,         32'h0);

        // Release reset with a conflicting, illegal request held throughout the sweep
        RESET        = 1'b0;
        bus.daddr    = 10'd1000;
        bus.funct3   = 3'b111;
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b1;
        bus.ddata_w  = 32'hFFFF_FFFF;
        wait_ready(cycles, saw_rvalid, saw_err);
        bus_idle();
        chk("clear_cycles", cycles, 32'd1024);
        chk("clear_no_rvalid", {31'd0, saw_rvalid}, 32'd0);
        chk("clear_no_err",    {31'd0, saw_err},    32'd0);

        load("lw_cleared_1000", 10'd1000, 2'd0, LW, 32'h0);
        load("lw_cleared_100",  10'd100,  2'd0, LW, 32'h0);

        // Store then load on the very next cycle
        store(10'd5, 2'd0, LW, 32'hDEAD_BEEF);
        load("lw_b2b", 10'd5, 2'd0, LW, 32'hDEAD_BEEF);
        tick();
        chk("rvalid_pulse", {31'd0, bus.rvalid}, 32'd0);

        // Byte store into lane 2, then the extension variants
        store(10'd5, 2'd2, LB, 32'h0000_007F);
        load("lw_after_sb",  10'd5, 2'd0, LW,  32'hDE7F_BEEF);
        load("lb_off3",      10'd5, 2'd3, LB,  32'hFFFF_FFDE);
        load("lbu_off3",     10'd5, 2'd3, LBU, 32'h0000_00DE);
        load("lh_off2",      10'd5, 2'd2, LH,  32'hFFFF_DE7F);
        load("lhu_off0",     10'd5, 2'd0, LHU, 32'h0000_BEEF);
        chk("err_clean", {31'd0, bus.ERR}, 32'd0);

        // Misaligned load answers with zero and sets ERR
        load("lh_misaligned", 10'd5, 2'd1, LH, 32'h0);
        chk("err_misaligned", {31'd0, bus.ERR}, 32'd1);
        store(10'd5, 2'd2, LW, 32'h1111_1111);
        load("lw_after_bad_sw", 10'd5, 2'd0, LW, 32'hDE7F_BEEF);
        chk("err_sticky", {31'd0, bus.ERR}, 32'd1);

        // Reset from IDLE clears ERR; reset at sweep cycle 300 restarts the sweep
        RESET = 1'b1;
        tick(); tick();
        chk("rst2_err",   {31'd0, bus.ERR},   32'd0);
        chk("rst2_ready", {31'd0, bus.READY}, 32'd0);
        RESET = 1'b0;
        repeat (300) tick();
        chk("mid_clear_ready", {31'd0, bus.READY}, 32'd0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        wait_ready(cycles, saw_rvalid, saw_err);
        chk("restart_cycles", cycles, 32'd1024);
        load("lw_swept_5", 10'd5, 2'd0, LW, 32'h0);

        // MemRead and MemWrite together: write only, no rvalid, ERR set
        drive(1'b1, 1'b1, 10'd9, 2'd0, LW, 32'h1234_5678);
        chk("conf_rvalid_a", {31'd0, bus.rvalid}, 32'd0);
        tick();
        chk("conf_rvalid_b", {31'd0, bus.rvalid}, 32'd0);
        chk("conf_err",      {31'd0, bus.ERR},    32'd1);
        load("lw_conf_9", 10'd9, 2'd0, LW, 32'h1234_5678);

        // Half store to upper lanes, undefined store code, undefined load code
        store(10'd9, 2'd2, LH, 32'h0000_ABCD);
        load("lw_after_sh", 10'd9, 2'd0, LW, 32'hABCD_5678);
        store(10'd9, 2'd0, 3'b011, 32'h0);
        load("lw_after_f3_011", 10'd9, 2'd0, LW, 32'hABCD_5678);
        load("load_f3_110", 10'd9, 2'd0, 3'b110, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
